// File: rtl/gelato_compute_unit.sv
// Warp-wide ALU slave for the compute_task handshake: LANES threads per beat, THREAD_NUM/LANES beats.
// Optional multiplier support for op 10 is enabled by defining GELATO_CU_MUL_EN.
module gelato_compute_unit #(
    parameter int unsigned THREAD_NUM = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned LANES      = 8
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             task_valid,
    input  logic [3:0]                       task_op,
    input  logic [THREAD_NUM*DATA_WIDTH-1:0] task_rs1,
    input  logic [THREAD_NUM*DATA_WIDTH-1:0] task_rs2,
    output logic                             task_done,
    output logic [THREAD_NUM*DATA_WIDTH-1:0] task_rd,
    output logic                             task_err,
    output logic                             busy
);

    localparam int unsigned BEATS   = THREAD_NUM / LANES;
    localparam int unsigned VEC_W   = THREAD_NUM * DATA_WIDTH;
    localparam int unsigned SLICE_W = LANES * DATA_WIDTH;
    localparam int unsigned BEAT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned SH_W    = $clog2(DATA_WIDTH);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_SLL  = 4'd5;
    localparam logic [3:0] OP_SRL  = 4'd6;
    localparam logic [3:0] OP_SRA  = 4'd7;
    localparam logic [3:0] OP_SLT  = 4'd8;
    localparam logic [3:0] OP_SLTU = 4'd9;
    localparam logic [3:0] OP_MUL  = 4'd10;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE,
        S_RELEASE
    } state_t;

    state_t                r_state;
    logic [BEAT_W-1:0]     r_beat;
    logic [3:0]            r_op;
    logic [VEC_W-1:0]      r_rs1;
    logic [VEC_W-1:0]      r_rs2;
    logic [VEC_W-1:0]      r_rd;
    logic                  r_done;
    logic                  r_err;
    logic                  r_busy;

    logic [SLICE_W-1:0]    w_rs1_slice;
    logic [SLICE_W-1:0]    w_rs2_slice;
    logic [SLICE_W-1:0]    w_res;
    logic                  w_illegal;

    // One thread's result; illegal ops fall through to zero.
    function automatic logic [DATA_WIDTH-1:0] f_alu(
        input logic [3:0]            op,
        input logic [DATA_WIDTH-1:0] a,
        input logic [DATA_WIDTH-1:0] b
    );
        logic [SH_W-1:0] sh;
        sh    = b[SH_W-1:0];
        f_alu = '0;
        case (op)
            OP_ADD:  f_alu = a + b;
            OP_SUB:  f_alu = a - b;
            OP_AND:  f_alu = a & b;
            OP_OR:   f_alu = a | b;
            OP_XOR:  f_alu = a ^ b;
            OP_SLL:  f_alu = a << sh;
            OP_SRL:  f_alu = a >> sh;
            OP_SRA:  f_alu = DATA_WIDTH'($signed(a) >>> sh);
            OP_SLT:  f_alu = DATA_WIDTH'($signed(a) < $signed(b));
            OP_SLTU: f_alu = DATA_WIDTH'(a < b);
`ifdef GELATO_CU_MUL_EN
            OP_MUL:  f_alu = a * b;
`endif
            default: f_alu = '0;
        endcase
    endfunction

    assign w_rs1_slice = r_rs1[r_beat*SLICE_W +: SLICE_W];
    assign w_rs2_slice = r_rs2[r_beat*SLICE_W +: SLICE_W];

`ifdef GELATO_CU_MUL_EN
    assign w_illegal = (r_op > OP_MUL);
`else
    assign w_illegal = (r_op >= OP_MUL);
`endif

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        assign w_res[l*DATA_WIDTH +: DATA_WIDTH] =
            f_alu(r_op, w_rs1_slice[l*DATA_WIDTH +: DATA_WIDTH], w_rs2_slice[l*DATA_WIDTH +: DATA_WIDTH]);
    end

    // Handshake FSM; RELEASE waits for valid to drop so a held request is never re-accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_beat  <= '0;
            r_op    <= '0;
            r_rs1   <= '0;
            r_rs2   <= '0;
            r_rd    <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (task_valid) begin
                        r_op    <= task_op;
                        r_rs1   <= task_rs1;
                        r_rs2   <= task_rs2;
                        r_beat  <= '0;
                        r_err   <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (!task_valid) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_rd[r_beat*SLICE_W +: SLICE_W] <= w_res;
                        r_beat <= r_beat + BEAT_W'(1);
                        if (r_beat == BEAT_W'(BEATS - 1)) begin
                            r_done  <= 1'b1;
                            r_err   <= w_illegal;
                            r_state <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_RELEASE;
                end
                S_RELEASE: begin
                    if (!task_valid) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign task_done = r_done;
    assign task_rd   = r_rd;
    assign task_err  = r_err;
    assign busy      = r_busy;

endmodule
